// File: rtl/seg7_scan_driver.sv
// Frame-synchronous 4-digit common-anode seven-segment scanner.
// Digit codes and masks are snapshotted once per frame so the display never shows a torn frame.
module seg7_scan_driver #(
  parameter int PRESCALE    = 100000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] blank,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          primed;
  logic [3:0]    sa, sb, sc, sd;
  logic [3:0]    sh_blank, sh_dp;

  logic          wrap;
  logic          load;
  logic          lit;
  logic [1:0]    pos;
  logic [3:0]    code;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    s = 7'h7f;
    unique case (c)
      4'd0:  s = 7'b1000000;
      4'd1:  s = 7'b1111001;
      4'd2:  s = 7'b0100100;
      4'd3:  s = 7'b0110000;
      4'd4:  s = 7'b0011001;
      4'd5:  s = 7'b0010010;
      4'd6:  s = 7'b0000010;
      4'd7:  s = 7'b1111000;
      4'd8:  s = 7'b0000000;
      4'd9:  s = 7'b0010000;
      4'd10: s = 7'b0101111;
      4'd11: s = 7'b0100001;
      4'd12: s = 7'b0010001;
      4'd13: s = 7'b1000010;
      4'd14: s = 7'b0000110;
      4'd15: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // idx 0 drives the leftmost digit (an[3]), so the bit position is ~idx
  always_comb begin
    wrap = (cnt == CW'(PRESCALE - 1));
    load = !primed || (wrap && idx == 2'd3);
    pos  = ~idx;
    code = sa;
    unique case (idx)
      2'd0: code = sa;
      2'd1: code = sb;
      2'd2: code = sc;
      2'd3: code = sd;
    endcase
    lit = (cnt >= CW'(DEAD_CYCLES)) && !sh_blank[pos];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      primed     <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      sc         <= '0;
      sd         <= '0;
      sh_blank   <= 4'b1111;
      sh_dp      <= '0;
      frame_tick <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
    end else begin
      // the priming edge only loads; scanning starts on the next edge
      if (!primed) begin
        primed <= 1'b1;
      end else begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap) idx <= idx + 1'b1;
      end
      if (load) begin
        sa       <= A;
        sb       <= B;
        sc       <= C;
        sd       <= D;
        sh_blank <= blank;
        sh_dp    <= dp_en;
      end
      frame_tick <= load;
      an  <= lit ? ~(4'b1000 >> idx) : 4'b1111;
      seg <= lit ? decode(code) : 7'b1111111;
      dp  <= lit ? ~sh_dp[pos] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with PRESCALE=8, DEAD_CYCLES=2.
// Edge e counts clock edges after reset release; outputs sampled 1 ns after each edge.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] A = 4'd0, B = 4'd0, C = 4'd0, D = 4'd0;
  logic [3:0] blank = 4'd0, dp_en = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int total = 0;
  int bad = 0;
  int e = -1;

  seg7_scan_driver #(.PRESCALE(8), .DEAD_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .blank(blank),
    .dp_en(dp_en),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got=%0h exp=%0h", tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    chk("one_hot_an", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic step_to(input int n);
    while (e < n) tick();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    e = -1;
  endtask

  initial begin
    A = 4'd1; B = 4'd2; C = 4'd3; D = 4'd4;
    blank = 4'b0000; dp_en = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    release_reset();

    // frame 1: basic scan, ticks, dead time
    step_to(0);
    chk("ft_e0", 32'(frame_tick), 32'd1);
    chk("an_e0", 32'(an), 32'hf);
    step_to(1);
    chk("ft_e1", 32'(frame_tick), 32'd0);
    step_to(2);
    chk("dead_e2", 32'(an), 32'hf);
    step_to(3);
    chk("a_an", 32'(an), 32'b0111);
    chk("a_seg", 32'(seg), 32'b1111001);
    chk("a_dp", 32'(dp), 32'd1);
    step_to(8);
    chk("a_an_end", 32'(an), 32'b0111);
    step_to(9);
    chk("dead_e9", 32'(an), 32'hf);
    chk("dead_seg", 32'(seg), 32'h7f);
    step_to(11);
    chk("b_an", 32'(an), 32'b1011);
    chk("b_seg", 32'(seg), 32'b0100100);
    step_to(12);
    D = 4'd9;
    dp_en = 4'b0001;
    step_to(19);
    chk("c_an", 32'(an), 32'b1101);
    chk("c_seg", 32'(seg), 32'b0110000);
    step_to(27);
    chk("d_an", 32'(an), 32'b1110);
    chk("d_seg_old", 32'(seg), 32'b0011001);
    chk("d_dp_old", 32'(dp), 32'd1);
    step_to(31);
    chk("ft_e31", 32'(frame_tick), 32'd0);
    step_to(32);
    chk("ft_e32", 32'(frame_tick), 32'd1);
    chk("d_an_e32", 32'(an), 32'b1110);
    step_to(33);
    chk("ft_e33", 32'(frame_tick), 32'd0);

    // frame 2: new D and decimal point on D only
    step_to(35);
    chk("f2_a_an", 32'(an), 32'b0111);
    chk("f2_a_dp", 32'(dp), 32'd1);
    step_to(58);
    chk("f2_dead_an", 32'(an), 32'hf);
    chk("f2_dead_dp", 32'(dp), 32'd1);
    step_to(59);
    chk("f2_d_an", 32'(an), 32'b1110);
    chk("f2_d_seg", 32'(seg), 32'b0010000);
    chk("f2_d_dp", 32'(dp), 32'd0);
    step_to(60);
    blank = 4'b1000;
    B = 4'd10; C = 4'd11; D = 4'd12;
    dp_en = 4'b0000;
    step_to(64);
    chk("ft_e64", 32'(frame_tick), 32'd1);

    // frame 3: A blanked, letters r/d/y
    step_to(67);
    chk("f3_a_blank", 32'(an), 32'hf);
    step_to(70);
    chk("f3_a_blank2", 32'(an), 32'hf);
    step_to(75);
    chk("f3_b_an", 32'(an), 32'b1011);
    chk("f3_b_seg", 32'(seg), 32'b0101111);
    step_to(76);
    blank = 4'b1111;
    step_to(83);
    chk("f3_c_an", 32'(an), 32'b1101);
    chk("f3_c_seg", 32'(seg), 32'b0100001);
    step_to(91);
    chk("f3_d_an", 32'(an), 32'b1110);
    chk("f3_d_seg", 32'(seg), 32'b0010001);
    step_to(96);
    chk("ft_e96", 32'(frame_tick), 32'd1);
    A = 4'd1; B = 4'd2; C = 4'd3; D = 4'd4;
    blank = 4'b0000;

    // frame 4: fully blanked
    for (int i = 97; i <= 128; i++) begin
      step_to(i);
      chk("f4_an", 32'(an), 32'hf);
      chk("f4_seg", 32'(seg), 32'h7f);
    end
    chk("ft_e128", 32'(frame_tick), 32'd1);

    // frame 5: reset during digit C
    step_to(149);
    chk("f5_c_an", 32'(an), 32'b1101);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an), 32'hf);
    chk("mid_rst_seg", 32'(seg), 32'h7f);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    repeat (2) @(negedge clk);
    release_reset();
    step_to(0);
    chk("rel_ft_e0", 32'(frame_tick), 32'd1);
    step_to(2);
    chk("rel_dead_e2", 32'(an), 32'hf);
    step_to(3);
    chk("rel_a_an", 32'(an), 32'b0111);
    chk("rel_a_seg", 32'(seg), 32'b1111001);
    step_to(32);
    chk("rel_ft_e32", 32'(frame_tick), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
